// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
// Shared types for the LC-3b pipelined datapath.
//   lc3b_control_word : decoded per-instruction control carried down the pipe.
//   lc3b_mem_state_t  : MEM-stage access sequencer states.
//   word_align()      : clears bit 0 of an address for word accesses.
// ----------------------------------------------------------------------------
package lc3b_types;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] lc3b_word;

   typedef struct packed {
      logic       regfile_load;     // WB writes the destination register
      logic [1:0] regfile_mux_sel;  // WB data source select
      logic       dmem_read;        // instruction reads data memory
      logic       dmem_write;       // instruction writes data memory
      logic       mem_byte;         // byte-sized access (LDB/STB)
      logic       mem_indirect;     // pointer-then-data access (LDI/STI)
   } lc3b_control_word;

   typedef enum logic {
      S_FIRST  = 1'b0,
      S_SECOND = 1'b1
   } lc3b_mem_state_t;

   function automatic lc3b_word word_align(input lc3b_word addr);
      return {addr[WORD_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/mem_data_align.sv
// ----------------------------------------------------------------------------
// mem_data_align
// Combinational byte-lane steering between the datapath and data memory.
//   i_byte        : access is byte sized
//   i_addr_lsb    : address bit 0, selects the byte lane
//   i_rdata       : raw memory read data
//   i_src         : store data from the register file
//   o_load_data   : load result (zero-extended lane for byte loads)
//   o_wdata       : memory write data (byte replicated for byte stores)
//   o_byte_enable : write lane mask
// ----------------------------------------------------------------------------
module mem_data_align
   import lc3b_types::*;
(
   input  logic        i_byte,
   input  logic        i_addr_lsb,
   input  logic [15:0] i_rdata,
   input  logic [15:0] i_src,
   output logic [15:0] o_load_data,
   output logic [15:0] o_wdata,
   output logic [1:0]  o_byte_enable
);

   logic [7:0] w_lane;

   // Odd byte address lives in the high lane (little-endian).
   assign w_lane = i_addr_lsb ? i_rdata[15:8] : i_rdata[7:0];

   assign o_load_data   = i_byte ? {8'h00, w_lane} : i_rdata;

   // Replicating the byte lets memory pick whichever lane is enabled.
   assign o_wdata       = i_byte ? {i_src[7:0], i_src[7:0]} : i_src;
   assign o_byte_enable = i_byte ? (i_addr_lsb ? 2'b10 : 2'b01) : 2'b11;

endmodule

// File: rtl/stage_mem.sv
// ----------------------------------------------------------------------------
// stage_mem
// Memory-access stage of the pipelined LC-3b datapath plus the MEM/WB
// pipeline register. Issues data-memory requests, sequences the two-access
// indirect ops (LDI/STI) and stalls upstream stages until memory responds.
//
// Build option: define LC3B_MEM_INDIRECT_EN to build the second-access state
// and pointer register. Without it, mem_indirect is ignored and every memory
// op is one access at alu_in.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   valid_in            : EX/MEM holds a real instruction
//   control_in          : decoded control word
//   alu_in              : ALU result / effective address
//   ir_in, pc_in, pcn_in: instruction, PC, next PC
//   src_in              : store data
//   dmem_rdata, dmem_resp                       : memory response
//   dmem_address, dmem_read, dmem_write,
//   dmem_byte_enable, dmem_wdata                : memory request
//   stall_out           : freeze IF/ID/EX and EX/MEM this cycle
//   valid_out .. pcn_out: MEM/WB register contents for WB
// ----------------------------------------------------------------------------
module stage_mem
   import lc3b_types::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  lc3b_control_word control_in,
   input  logic [15:0]      alu_in,
   input  logic [15:0]      ir_in,
   input  logic [15:0]      pc_in,
   input  logic [15:0]      pcn_in,
   input  logic [15:0]      src_in,
   input  logic [15:0]      dmem_rdata,
   input  logic             dmem_resp,
   output logic [15:0]      dmem_address,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic [1:0]       dmem_byte_enable,
   output logic [15:0]      dmem_wdata,
   output logic             stall_out,
   output logic             valid_out,
   output lc3b_control_word control_out,
   output logic [15:0]      alu_out,
   output logic [15:0]      ir_out,
   output logic [15:0]      mdr_out,
   output logic [15:0]      pc_out,
   output logic [15:0]      pcn_out
);

   logic        w_mem_op;
   logic [15:0] w_addr;
   logic        w_read;
   logic        w_write;
   logic        w_final;
   logic [15:0] w_load_data;
   logic [15:0] w_wdata;
   logic [1:0]  w_byte_enable;

   assign w_mem_op = valid_in & (control_in.dmem_read | control_in.dmem_write);

   mem_data_align u_align (
      .i_byte        (control_in.mem_byte),
      .i_addr_lsb    (alu_in[0]),
      .i_rdata       (dmem_rdata),
      .i_src         (src_in),
      .o_load_data   (w_load_data),
      .o_wdata       (w_wdata),
      .o_byte_enable (w_byte_enable)
   );

`ifdef LC3B_MEM_INDIRECT_EN
   lc3b_mem_state_t r_state;
   lc3b_mem_state_t w_state_next;
   logic [15:0]     r_ptr;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FIRST;
         r_ptr   <= 16'h0000;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_FIRST && w_mem_op && control_in.mem_indirect && dmem_resp)
            r_ptr <= dmem_rdata;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_addr       = alu_in;
      w_read       = 1'b0;
      w_write      = 1'b0;
      w_final      = 1'b1;
      case (r_state)
         S_FIRST: begin
            if (control_in.mem_indirect) begin
               // Pointer fetch: always a word read, never the final access.
               w_addr  = word_align(alu_in);
               w_read  = w_mem_op;
               w_final = 1'b0;
               if (w_mem_op && dmem_resp)
                  w_state_next = S_SECOND;
            end else begin
               w_addr  = control_in.mem_byte ? alu_in : word_align(alu_in);
               w_read  = w_mem_op & control_in.dmem_read;
               w_write = w_mem_op & control_in.dmem_write & ~control_in.dmem_read;
            end
         end
         S_SECOND: begin
            w_addr  = word_align(r_ptr);
            w_read  = w_mem_op & control_in.dmem_read;
            w_write = w_mem_op & control_in.dmem_write & ~control_in.dmem_read;
            if (w_mem_op && dmem_resp)
               w_state_next = S_FIRST;
         end
         default: w_state_next = S_FIRST;
      endcase
   end
`else
   always_comb begin
      w_final = 1'b1;
      w_addr  = control_in.mem_byte ? alu_in : word_align(alu_in);
      w_read  = w_mem_op & control_in.dmem_read;
      w_write = w_mem_op & control_in.dmem_write & ~control_in.dmem_read;
   end
`endif

   // Reset gates the strobes combinationally so an in-flight access is
   // abandoned in the same cycle reset rises.
   assign dmem_address     = w_addr;
   assign dmem_read        = w_read & ~reset;
   assign dmem_write       = w_write & ~reset;
   assign dmem_byte_enable = w_byte_enable;
   assign dmem_wdata       = w_wdata;
   assign stall_out        = w_mem_op & ~(dmem_resp & w_final) & ~reset;

   // MEM/WB pipeline register. A stall loads a bubble so WB never writes
   // the register file for a half-finished memory op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out   <= 1'b0;
         control_out <= '0;
         alu_out     <= 16'h0000;
         ir_out      <= 16'h0000;
         mdr_out     <= 16'h0000;
         pc_out      <= 16'h0000;
         pcn_out     <= 16'h0000;
      end else begin
         alu_out <= alu_in;
         ir_out  <= ir_in;
         pc_out  <= pc_in;
         pcn_out <= pcn_in;
         if (stall_out) begin
            valid_out   <= 1'b0;
            control_out <= '0;
            mdr_out     <= 16'h0000;
         end else begin
            valid_out   <= valid_in;
            control_out <= valid_in ? control_in : '0;
            mdr_out     <= (valid_in && control_in.dmem_read) ? w_load_data : 16'h0000;
         end
      end
   end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;
   import lc3b_types::*;

   logic             clk = 1'b0;
   logic             reset;
   logic             valid_in;
   lc3b_control_word control_in;
   logic [15:0]      alu_in, ir_in, pc_in, pcn_in, src_in;
   logic [15:0]      dmem_rdata;
   logic             dmem_resp;
   logic [15:0]      dmem_address;
   logic             dmem_read, dmem_write;
   logic [1:0]       dmem_byte_enable;
   logic [15:0]      dmem_wdata;
   logic             stall_out;
   logic             valid_out;
   lc3b_control_word control_out;
   logic [15:0]      alu_out, ir_out, mdr_out, pc_out, pcn_out;

   int checks   = 0;
   int failures = 0;

   stage_mem dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .control_in       (control_in),
      .alu_in           (alu_in),
      .ir_in            (ir_in),
      .pc_in            (pc_in),
      .pcn_in           (pcn_in),
      .src_in           (src_in),
      .dmem_rdata       (dmem_rdata),
      .dmem_resp        (dmem_resp),
      .dmem_address     (dmem_address),
      .dmem_read        (dmem_read),
      .dmem_write       (dmem_write),
      .dmem_byte_enable (dmem_byte_enable),
      .dmem_wdata       (dmem_wdata),
      .stall_out        (stall_out),
      .valid_out        (valid_out),
      .control_out      (control_out),
      .alu_out          (alu_out),
      .ir_out           (ir_out),
      .mdr_out          (mdr_out),
      .pc_out           (pc_out),
      .pcn_out          (pcn_out)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after the rising edge; combinational outputs are
   // sampled 3 ns later, registered outputs right after the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic v, input lc3b_control_word c,
                         input logic [15:0] alu, input logic [15:0] src);
      valid_in   = v;
      control_in = c;
      alu_in     = alu;
      src_in     = src;
      ir_in      = alu ^ 16'h5A5A;
      pc_in      = 16'h0100;
      pcn_in     = 16'h0102;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_op(1'b0, '0, 16'h0000, 16'h0000);
      dmem_rdata = 16'h0000;
      dmem_resp  = 1'b0;
      tick();
      tick();
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (control_out !== '0) begin failures++; $display("FAIL reset_control got=%h exp=0", control_out); end
      checks++; if (mdr_out !== 16'h0000) begin failures++; $display("FAIL reset_mdr got=%h exp=0000", mdr_out); end
      checks++; if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {dmem_read, dmem_write, stall_out}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_nonmem();
      lc3b_control_word c, cm;
      c = '0; c.regfile_load = 1'b1; c.regfile_mux_sel = 2'b01;
      set_op(1'b1, c, 16'h7777, 16'h0000);
      dmem_resp = 1'b1;  // stray response must be ignored
      #3;
      checks++; if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin failures++; $display("FAIL nonmem_strobes got=%b exp=000", {dmem_read, dmem_write, stall_out}); end
      tick();
      checks++; if (valid_out !== 1'b1 || control_out !== c) begin failures++; $display("FAIL nonmem_wb got=%b/%h exp=1/%h", valid_out, control_out, c); end
      checks++; if (alu_out !== 16'h7777 || mdr_out !== 16'h0000) begin failures++; $display("FAIL nonmem_data got=%h/%h exp=7777/0000", alu_out, mdr_out); end
      // Invalid instruction carrying a memory control word: no request, no stall.
      cm = '0; cm.dmem_read = 1'b1; cm.regfile_load = 1'b1;
      set_op(1'b0, cm, 16'h1000, 16'h0000);
      dmem_resp = 1'b0;
      #3;
      checks++; if ({dmem_read, stall_out} !== 2'b00) begin failures++; $display("FAIL invalid_strobes got=%b exp=00", {dmem_read, stall_out}); end
      tick();
      checks++; if (valid_out !== 1'b0 || control_out !== '0) begin failures++; $display("FAIL invalid_wb got=%b/%h exp=0/00", valid_out, control_out); end
   endtask

   task automatic test_ldr();
      lc3b_control_word c;
      c = '0; c.dmem_read = 1'b1; c.regfile_load = 1'b1;
      set_op(1'b1, c, 16'h1235, 16'h0000);
      dmem_rdata = 16'hBEEF;
      for (int k = 0; k < 3; k++) begin
         dmem_resp = (k == 2);
         #3;
         checks++; if (stall_out !== (k < 2)) begin failures++; $display("FAIL ldr_stall cyc=%0d got=%b exp=%b", k, stall_out, (k < 2)); end
         checks++; if (dmem_address !== 16'h1234 || dmem_read !== 1'b1 || dmem_write !== 1'b0) begin failures++; $display("FAIL ldr_req cyc=%0d got=%h r%b w%b exp=1234 r1 w0", k, dmem_address, dmem_read, dmem_write); end
         tick();
         if (k < 2) begin
            checks++; if (valid_out !== 1'b0 || control_out !== '0) begin failures++; $display("FAIL ldr_bubble cyc=%0d got=%b/%h exp=0/00", k, valid_out, control_out); end
         end
      end
      checks++; if (mdr_out !== 16'hBEEF || valid_out !== 1'b1 || control_out !== c) begin failures++; $display("FAIL ldr_wb got=%h v%b c%h exp=beef v1 c%h", mdr_out, valid_out, control_out, c); end
   endtask

   task automatic test_ldb();
      lc3b_control_word c;
      c = '0; c.dmem_read = 1'b1; c.mem_byte = 1'b1; c.regfile_load = 1'b1;
      set_op(1'b1, c, 16'h2001, 16'h0000);
      dmem_rdata = 16'hA55A;
      dmem_resp  = 1'b1;
      #3;
      checks++; if (stall_out !== 1'b0 || dmem_address !== 16'h2001 || dmem_read !== 1'b1) begin failures++; $display("FAIL ldb_req got=s%b %h r%b exp=s0 2001 r1", stall_out, dmem_address, dmem_read); end
      tick();
      checks++; if (mdr_out !== 16'h00A5 || valid_out !== 1'b1) begin failures++; $display("FAIL ldb_mdr got=%h v%b exp=00a5 v1", mdr_out, valid_out); end
      // Even byte address selects the low lane.
      set_op(1'b1, c, 16'h2002, 16'h0000);
      #3;
      tick();
      checks++; if (mdr_out !== 16'h005A) begin failures++; $display("FAIL ldb_even got=%h exp=005a", mdr_out); end
   endtask

   task automatic test_stb();
      lc3b_control_word c;
      c = '0; c.dmem_write = 1'b1; c.mem_byte = 1'b1;
      set_op(1'b1, c, 16'h3000, 16'h12CD);
      for (int k = 0; k < 2; k++) begin
         dmem_resp = (k == 1);
         #3;
         checks++; if (dmem_wdata !== 16'hCDCD || dmem_byte_enable !== 2'b01 || dmem_write !== 1'b1 || dmem_read !== 1'b0) begin failures++; $display("FAIL stb_req cyc=%0d got=%h be%b w%b r%b exp=cdcd be01 w1 r0", k, dmem_wdata, dmem_byte_enable, dmem_write, dmem_read); end
         checks++; if (stall_out !== (k == 0)) begin failures++; $display("FAIL stb_stall cyc=%0d got=%b exp=%b", k, stall_out, (k == 0)); end
         tick();
      end
      checks++; if (valid_out !== 1'b1 || mdr_out !== 16'h0000) begin failures++; $display("FAIL stb_wb got=v%b %h exp=v1 0000", valid_out, mdr_out); end
      // Odd byte store enables the high lane.
      set_op(1'b1, c, 16'h3001, 16'h12CD);
      #3;
      checks++; if (dmem_byte_enable !== 2'b10) begin failures++; $display("FAIL stb_odd_be got=%b exp=10", dmem_byte_enable); end
      tick();
   endtask

   task automatic test_ldi();
      lc3b_control_word c;
      c = '0; c.dmem_read = 1'b1; c.mem_indirect = 1'b1; c.regfile_load = 1'b1;
      set_op(1'b1, c, 16'h4000, 16'h0000);
      dmem_rdata = 16'h5002;
      dmem_resp  = 1'b0;
      #3;
      checks++; if (dmem_address !== 16'h4000 || dmem_read !== 1'b1 || stall_out !== 1'b1) begin failures++; $display("FAIL ldi_first got=%h r%b s%b exp=4000 r1 s1", dmem_address, dmem_read, stall_out); end
      tick();
      dmem_resp = 1'b1;
      #3;
`ifdef LC3B_MEM_INDIRECT_EN
      checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL ldi_ptr_stall got=%b exp=1", stall_out); end
      tick();
      checks++; if (control_out !== '0 || valid_out !== 1'b0) begin failures++; $display("FAIL ldi_bubble got=%h v%b exp=00 v0", control_out, valid_out); end
      dmem_resp  = 1'b0;
      dmem_rdata = 16'h0777;
      #3;
      checks++; if (dmem_address !== 16'h5002 && dmem_address !== 16'h5002) begin failures++; end
      checks++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || stall_out !== 1'b1) begin failures++; $display("FAIL ldi_second got=%h r%b w%b s%b exp=5002 r1 w0 s1", dmem_address, dmem_read, dmem_write, stall_out); end
      tick();
      dmem_resp = 1'b1;
      #3;
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL ldi_done_stall got=%b exp=0", stall_out); end
      tick();
      checks++; if (mdr_out !== 16'h0777 || valid_out !== 1'b1) begin failures++; $display("FAIL ldi_wb got=%h v%b exp=0777 v1", mdr_out, valid_out); end
`else
      checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL ldi_single_stall got=%b exp=0", stall_out); end
      tick();
      checks++; if (mdr_out !== 16'h5002 || valid_out !== 1'b1) begin failures++; $display("FAIL ldi_single_wb got=%h v%b exp=5002 v1", mdr_out, valid_out); end
`endif
   endtask

   task automatic test_sti_reset();
      lc3b_control_word c, cl;
      c = '0; c.dmem_write = 1'b1; c.mem_indirect = 1'b1;
      set_op(1'b1, c, 16'h4000, 16'h1111);
      dmem_rdata = 16'h6000;
`ifdef LC3B_MEM_INDIRECT_EN
      dmem_resp = 1'b1;
      #3;
      checks++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || stall_out !== 1'b1) begin failures++; $display("FAIL sti_ptr got=r%b w%b s%b exp=r1 w0 s1", dmem_read, dmem_write, stall_out); end
      tick();
      dmem_resp = 1'b0;
      #3;
      checks++; if (dmem_address !== 16'h6000 || dmem_write !== 1'b1 || dmem_read !== 1'b0) begin failures++; $display("FAIL sti_second got=%h w%b r%b exp=6000 w1 r0", dmem_address, dmem_write, dmem_read); end
`else
      dmem_resp = 1'b0;
      #3;
      checks++; if (dmem_address !== 16'h4000 || dmem_write !== 1'b1) begin failures++; $display("FAIL sti_single got=%h w%b exp=4000 w1", dmem_address, dmem_write); end
`endif
      reset = 1'b1;
      #1;
      checks++; if ({dmem_read, dmem_write} !== 2'b00) begin failures++; $display("FAIL sti_reset_strobes got=%b exp=00", {dmem_read, dmem_write}); end
      tick();
      checks++; if (valid_out !== 1'b0 || control_out !== '0 || alu_out !== 16'h0000 || mdr_out !== 16'h0000) begin failures++; $display("FAIL sti_reset_regs got=v%b c%h a%h m%h exp=all zero", valid_out, control_out, alu_out, mdr_out); end
      reset = 1'b0;
      cl = '0; cl.dmem_read = 1'b1; cl.regfile_load = 1'b1;
      set_op(1'b1, cl, 16'h0100, 16'h0000);
      dmem_rdata = 16'h1234;
      dmem_resp  = 1'b1;
      #3;
      checks++; if (dmem_address !== 16'h0100 || dmem_read !== 1'b1 || stall_out !== 1'b0) begin failures++; $display("FAIL post_reset_ldr got=%h r%b s%b exp=0100 r1 s0", dmem_address, dmem_read, stall_out); end
      tick();
      checks++; if (mdr_out !== 16'h1234 || valid_out !== 1'b1) begin failures++; $display("FAIL post_reset_wb got=%h v%b exp=1234 v1", mdr_out, valid_out); end
   endtask

   task automatic test_back_to_back();
      lc3b_control_word cl, cs;
      cl = '0; cl.dmem_read = 1'b1; cl.regfile_load = 1'b1;
      cs = '0; cs.dmem_write = 1'b1;
      set_op(1'b1, cl, 16'h0A00, 16'h0000);
      dmem_rdata = 16'h0F0F;
      dmem_resp  = 1'b1;
      #3;
      tick();
      set_op(1'b1, cs, 16'h0B03, 16'hC0DE);
      #3;
      checks++; if (dmem_write !== 1'b1 || dmem_address !== 16'h0B02 || dmem_wdata !== 16'hC0DE || dmem_byte_enable !== 2'b11) begin failures++; $display("FAIL b2b_str got=w%b %h %h be%b exp=w1 0b02 c0de be11", dmem_write, dmem_address, dmem_wdata, dmem_byte_enable); end
      checks++; if (mdr_out !== 16'h0F0F) begin failures++; $display("FAIL b2b_ldr_wb got=%h exp=0f0f", mdr_out); end
      tick();
      checks++; if (valid_out !== 1'b1 || control_out !== cs || mdr_out !== 16'h0000) begin failures++; $display("FAIL b2b_str_wb got=v%b c%h m%h exp=v1 c%h m0000", valid_out, control_out, mdr_out, cs); end
      set_op(1'b0, '0, 16'h0000, 16'h0000);
      dmem_resp = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_ldr();
      test_ldb();
      test_stb();
      test_ldi();
      test_sti_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
